x_pkt_deframer: RTL and testbench
=================================

X_PKT_DEFRAMER -- requirements
Module: x_pkt_deframer

Interface
REQ-001 SHALL have parameter p_sync, default 8'hA5, the start-of-packet byte value.
REQ-002 SHALL have parameter p_max_len, default 16, the maximum payload length in bytes (range 1..255).
REQ-003 SHALL have parameter p_timeout, default 1_000_000, the inter-byte timeout in clock cycles.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_valid  input  1  one-cycle strobe that a received byte is on i_data; there is no backpressure.
REQ-007 SHALL have port i_data  input  8  received byte.
REQ-008 SHALL have port o_valid  output  1  payload byte available.
REQ-009 SHALL have port o_data  output  8  payload byte.
REQ-010 SHALL have port o_last  output  1  o_data is the final payload byte of the packet.
REQ-011 SHALL have port i_accept  input  1  consumer takes o_data this cycle.
REQ-012 SHALL have port o_pkt_ok  output  1  one-cycle pulse when a packet passes its checksum.
REQ-013 SHALL have port o_err  output  1  one-cycle pulse when a packet is discarded.
REQ-014 SHALL have port o_err_code  output  2  error code: 1 = bad length, 2 = bad checksum, 3 = timeout; value is held until the next o_err.
REQ-015 SHALL have port o_drop  output  1  one-cycle pulse when an input byte is discarded during DRAIN.

Function
REQ-016 SHALL frame each packet as: p_sync byte, LEN byte, LEN payload bytes, CSUM byte.
REQ-017 SHALL define CSUM as the XOR of LEN and all payload bytes.
REQ-018 SHALL implement the states IDLE, LEN, PAYLOAD, CSUM and DRAIN; reset state is IDLE.
REQ-019 SHALL, in IDLE, move to LEN on i_valid with i_data==p_sync, and silently ignore all other bytes.
REQ-020 SHALL, in LEN, act on i_valid as follows:
- LEN==0: capture it and go to CSUM.
- 1 <= LEN <= p_max_len: capture it and go to PAYLOAD.
- LEN > p_max_len: go to IDLE and pulse o_err with code 1.
REQ-021 SHALL, in PAYLOAD, write each i_valid byte to buffer[wr_ptr], increment wr_ptr, and go to CSUM after LEN bytes.
REQ-022 SHALL keep a running XOR that starts at LEN and is updated with each payload byte.
REQ-023 SHALL, in CSUM, compare the i_valid byte with the running XOR:
- Mismatch: go to IDLE and pulse o_err with code 2.
- Match with LEN>0: go to DRAIN and pulse o_pkt_ok.
- Match with LEN==0: go to IDLE and pulse o_pkt_ok.
REQ-024 SHALL register the o_pkt_ok and o_err pulses so they occur in the cycle after the deciding byte; o_pkt_ok rises in the same cycle o_valid first rises.
REQ-025 SHALL release no payload byte before the packet's checksum has passed.
REQ-026 SHALL, in DRAIN, hold o_valid=1 and drive o_data=buffer[rd_ptr] and o_last=(rd_ptr==LEN-1).
REQ-027 SHALL, in DRAIN, increment rd_ptr on o_valid&i_accept, and go to IDLE in the cycle after the o_last byte is accepted.
REQ-028 SHALL hold o_data and o_last stable while o_valid=1 and i_accept=0.
REQ-029 SHALL, in DRAIN, discard every i_valid byte (including p_sync) and pulse o_drop in the next cycle.
REQ-030 SHALL count consecutive cycles without i_valid in LEN, PAYLOAD and CSUM; on reaching p_timeout it SHALL go to IDLE and pulse o_err with code 3.
REQ-031 SHALL clear the timeout counter on any i_valid and on every state change; i_valid in the same cycle as the timeout wins over the timeout.
REQ-032 SHALL hold o_valid=0 in every state other than DRAIN.
REQ-033 SHALL clear wr_ptr, rd_ptr and the running XOR on every entry to LEN.

Reset
REQ-034 SHALL, on i_rst=1 at a clock edge, set the state to IDLE and clear o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, the pointers, the XOR and the timeout counter.
REQ-035 SHALL abandon any partial or draining packet on reset without pulsing o_err.
REQ-036 SHALL NOT require the payload buffer contents to be reset.

Verification
REQ-037 SHALL cover the good packet case: A5 03 11 22 33 03 with i_accept=1 -> o_pkt_ok pulses once; o_data shows 11, 22, 33 on consecutive cycles; o_last is set with 33.
REQ-038 SHALL cover the bad checksum case: A5 02 10 20 00 -> o_err pulses with o_err_code=2 and o_valid never rises.
REQ-039 SHALL cover the bad length case: A5 11 with p_max_len=16 -> o_err pulses with code 1; a following A5 01 7E 7F is delivered as the single byte 7E with o_last=1.
REQ-040 SHALL cover the timeout case: A5 02 55 followed by p_timeout idle cycles -> o_err pulses with code 3 and the state returns to IDLE.
REQ-041 SHALL cover backpressure during DRAIN: i_accept=0 for 5 cycles mid-drain -> o_data is held; a byte arriving meanwhile pulses o_drop; all payload bytes are delivered in order.
REQ-042 SHALL cover reset during operation: i_rst asserted during PAYLOAD and again during DRAIN -> all outputs are 0 the next cycle; a following good packet is delivered correctly.

Source files
------------

// File: rtl/x_pkt_deframer.sv
// x_pkt_deframer: extracts payloads from SYNC/LEN/PAYLOAD/CSUM byte frames,
// buffers each payload and releases it to the consumer only after the checksum passes.
// Ports:
//   i_clk, i_rst                sync active-high reset
//   i_valid, i_data             received byte strobe (no backpressure)
//   o_valid, o_data, o_last,    payload stream out; the consumer takes a byte
//   i_accept                    when it asserts i_accept
//   o_pkt_ok                    pulse: packet checksum good
//   o_err, o_err_code           pulse and held code: 1 len, 2 csum, 3 timeout
//   o_drop                      pulse: input byte discarded while draining
module x_pkt_deframer #(
    parameter logic [7:0] p_sync    = 8'hA5,
    parameter int         p_max_len = 16,
    parameter int         p_timeout = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    input  logic       i_accept,
    output logic       o_pkt_ok,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_drop
);

    localparam int AW    = (p_max_len > 1) ? $clog2(p_max_len) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(p_timeout + 1);

    localparam logic [7:0]    MAX_LEN  = 8'(p_max_len);
    localparam logic [TW-1:0] TMO_LAST = TW'(p_timeout - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    len_q;
    logic [7:0]    wr_ptr_q;
    logic [7:0]    rd_ptr_q;
    logic [7:0]    xor_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    buf_mem [DEPTH];

    logic       ok_d;
    logic       err_d;
    logic [1:0] code_d;
    logic       drop_d;
    logic       wr_en;
    logic       timed;
    logic       tmo_hit;
    logic       last_w;

    assign timed   = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                   || (state_q == S_CSUM);
    // A byte arriving in the expiring cycle keeps the packet alive.
    assign tmo_hit = timed && !i_valid && (tmo_q == TMO_LAST);
    assign last_w  = (rd_ptr_q == len_q - 8'd1);

    assign o_valid = (state_q == S_DRAIN);
    assign o_last  = o_valid && last_w;
    assign o_data  = o_valid ? buf_mem[rd_ptr_q[AW-1:0]] : 8'h00;

    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = 2'd0;
        drop_d  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid && i_data == p_sync) state_d = S_LEN;
            end
            S_LEN: begin
                if (i_valid) begin
                    unique case (1'b1)
                        (i_data == 8'd0): state_d = S_CSUM;
                        (i_data > MAX_LEN): begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                            code_d  = 2'd1;
                        end
                        default: state_d = S_PAYLOAD;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == len_q - 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (i_valid) begin
                    if (i_data != xor_q) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = (len_q == 8'd0) ? S_IDLE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drop_d = i_valid;
                if (i_accept && last_w) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q      <= 8'd0;
            wr_ptr_q   <= 8'd0;
            rd_ptr_q   <= 8'd0;
            xor_q      <= 8'd0;
            tmo_q      <= '0;
            o_pkt_ok   <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
            o_drop     <= 1'b0;
        end else begin
            o_pkt_ok <= ok_d;
            o_err    <= err_d;
            o_drop   <= drop_d;
            if (err_d) o_err_code <= code_d;
            if (state_q == S_IDLE && state_d == S_LEN) begin
                wr_ptr_q <= 8'd0;
                rd_ptr_q <= 8'd0;
                xor_q    <= 8'd0;
            end
            // The running checksum is seeded with the length byte.
            if (state_q == S_LEN && i_valid) begin
                len_q <= i_data;
                xor_q <= i_data;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 8'd1;
                xor_q    <= xor_q ^ i_data;
            end
            if (o_valid && i_accept) rd_ptr_q <= rd_ptr_q + 8'd1;
            if (!timed || i_valid || state_d != state_q) tmo_q <= '0;
            else                                         tmo_q <= tmo_q + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) buf_mem[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: tb/tb_x_pkt_deframer.sv
// tb_x_pkt_deframer: directed and randomized checks of x_pkt_deframer
// against a packet-level reference model.
module tb_x_pkt_deframer;

    localparam int         T    = 40;
    localparam int         ML   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_accept;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_pkt_ok;
    logic       o_err;
    logic [1:0] o_err_code;
    logic       o_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q [$];
    bit         rxl_q [$];
    int         err_q [$];
    int         ok_cnt    = 0;
    int         drop_cnt  = 0;
    int         valid_cnt = 0;

    always #5 clk = ~clk;

    x_pkt_deframer #(
        .p_sync(SYNC),
        .p_max_len(ML),
        .p_timeout(T)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_valid(o_valid),
        .o_data(o_data),
        .o_last(o_last),
        .i_accept(i_accept),
        .o_pkt_ok(o_pkt_ok),
        .o_err(o_err),
        .o_err_code(o_err_code),
        .o_drop(o_drop)
    );

    // Passive monitor, sampled mid-cycle where inputs and outputs are stable.
    always @(negedge clk) begin
        if (o_valid) valid_cnt++;
        if (o_valid && i_accept) begin
            rx_q.push_back(o_data);
            rxl_q.push_back(o_last);
        end
        if (o_pkt_ok) ok_cnt++;
        if (o_err) err_q.push_back(int'(o_err_code));
        if (o_drop) drop_cnt++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        tick();
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic wait_drain(input bit rnd);
        for (int i = 0; i < 200 && o_valid; i++) begin
            if (rnd) i_accept = 1'($urandom_range(0, 1));
            tick();
        end
        i_accept = 1'b1;
        if (o_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_bound o_valid still %0b exp 0", o_valid);
        end
    endtask

    task automatic test_reset();
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_data   = 8'h00;
        i_accept = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, o_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outs got=%b exp=0",
                     {o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, o_data});
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_good();
        int ok0 = ok_cnt;
        i_accept = 1'b1;
        send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h03);
        n_checks++;
        if ({o_pkt_ok, o_valid, o_last, o_data} !== {1'b1, 1'b1, 1'b0, 8'h11}) begin
            n_fail++;
            $display("FAIL good_b0 got=%h exp=%h", {o_pkt_ok, o_valid, o_last, o_data},
                     {1'b1, 1'b1, 1'b0, 8'h11});
        end
        tick();
        n_checks++;
        if ({o_pkt_ok, o_valid, o_last, o_data} !== {1'b0, 1'b1, 1'b0, 8'h22}) begin
            n_fail++;
            $display("FAIL good_b1 got=%h exp=%h", {o_pkt_ok, o_valid, o_last, o_data},
                     {1'b0, 1'b1, 1'b0, 8'h22});
        end
        tick();
        n_checks++;
        if ({o_pkt_ok, o_valid, o_last, o_data} !== {1'b0, 1'b1, 1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL good_b2 got=%h exp=%h", {o_pkt_ok, o_valid, o_last, o_data},
                     {1'b0, 1'b1, 1'b1, 8'h33});
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_end o_valid=%b exp=0", o_valid);
        end
        send(SYNC); send(8'h00); send(8'h00);
        n_checks++;
        if ({o_pkt_ok, o_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL len0 got ok,valid=%b exp=10", {o_pkt_ok, o_valid});
        end
        tick();
        n_checks++;
        if (ok_cnt - ok0 !== 2) begin
            n_fail++;
            $display("FAIL good_okcnt got=%0d exp=2", ok_cnt - ok0);
        end
    endtask

    task automatic test_bad_csum();
        int v0 = valid_cnt;
        send(SYNC); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        n_checks++;
        if ({o_err, o_err_code} !== 3'b110) begin
            n_fail++;
            $display("FAIL csum_err got=%b exp=110", {o_err, o_err_code});
        end
        repeat (3) tick();
        n_checks++;
        if (valid_cnt !== v0) begin
            n_fail++;
            $display("FAIL csum_novalid got=%0d exp=%0d", valid_cnt, v0);
        end
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL csum_pulse o_err=%b exp=0", o_err);
        end
    endtask

    task automatic test_bad_len();
        send(SYNC); send(8'h11);
        n_checks++;
        if ({o_err, o_err_code, o_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL len_err got=%b exp=1010", {o_err, o_err_code, o_valid});
        end
        send(SYNC); send(8'h01); send(8'h7E); send(8'h7F);
        n_checks++;
        if ({o_pkt_ok, o_valid, o_last, o_data} !== {1'b1, 1'b1, 1'b1, 8'h7E}) begin
            n_fail++;
            $display("FAIL len_next got=%h exp=%h", {o_pkt_ok, o_valid, o_last, o_data},
                     {1'b1, 1'b1, 1'b1, 8'h7E});
        end
        n_checks++;
        if (o_err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL len_code_hold got=%0d exp=1", o_err_code);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len_next_end o_valid=%b exp=0", o_valid);
        end
    endtask

    task automatic test_timeout();
        int e0;
        send(SYNC); send(8'h02); send(8'h55);
        e0 = err_q.size();
        repeat (T - 1) tick();
        n_checks++;
        if (err_q.size() !== e0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_early errs=%0d exp=%0d", err_q.size(), e0);
        end
        tick();
        n_checks++;
        if ({o_err, o_err_code} !== 3'b111) begin
            n_fail++;
            $display("FAIL tmo_err got=%b exp=111", {o_err, o_err_code});
        end
        send(SYNC); send(8'h01); send(8'h44); send(8'h45);
        n_checks++;
        if ({o_pkt_ok, o_valid, o_data} !== {1'b1, 1'b1, 8'h44}) begin
            n_fail++;
            $display("FAIL tmo_idle got=%h exp=%h", {o_pkt_ok, o_valid, o_data},
                     {1'b1, 1'b1, 8'h44});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] bp [5];
        logic [7:0] cs = 8'h05;
        int r0 = rx_q.size();
        int d0 = drop_cnt;
        for (int i = 0; i < 5; i++) begin
            bp[i] = 8'($urandom);
            cs ^= bp[i];
        end
        i_accept = 1'b1;
        send(SYNC); send(8'h05);
        for (int i = 0; i < 5; i++) send(bp[i]);
        send(cs);
        tick();
        i_accept = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) send(SYNC);
            else        tick();
            n_checks++;
            if ({o_valid, o_last, o_data} !== {1'b1, 1'b0, bp[1]}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got=%h exp=%h", k, {o_valid, o_last, o_data},
                         {1'b1, 1'b0, bp[1]});
            end
            if (k == 1) begin
                n_checks++;
                if (o_drop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_drop o_drop=%b exp=1", o_drop);
                end
            end
        end
        i_accept = 1'b1;
        wait_drain(1'b0);
        n_checks++;
        if (rx_q.size() - r0 !== 5) begin
            n_fail++;
            $display("FAIL bp_count got=%0d exp=5", rx_q.size() - r0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if ({rxl_q[r0+i], rx_q[r0+i]} !== {(i == 4), bp[i]}) begin
                    n_fail++;
                    $display("FAIL bp_byte%0d got=%h exp=%h", i,
                             {rxl_q[r0+i], rx_q[r0+i]}, {(i == 4), bp[i]});
                end
            end
        end
        n_checks++;
        if (drop_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL bp_dropcnt got=%0d exp=1", drop_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int e0 = err_q.size();
        int r0;
        logic [7:0] pl [3];
        i_accept = 1'b1;
        send(SYNC); send(8'h04); send(8'h01); send(8'h02);
        i_rst = 1'b1;
        tick();
        n_checks++;
        if ({o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, o_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_payload got=%b exp=0",
                     {o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, o_data});
        end
        i_rst = 1'b0;
        i_accept = 1'b0;
        send(SYNC); send(8'h02); send(8'hAA); send(8'hBB); send(8'h02 ^ 8'hAA ^ 8'hBB);
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_drain_pre o_valid=%b exp=1", o_valid);
        end
        tick();
        i_rst = 1'b1;
        tick();
        n_checks++;
        if ({o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, o_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_drain got=%b exp=0",
                     {o_valid, o_last, o_pkt_ok, o_err, o_drop, o_err_code, o_data});
        end
        i_rst = 1'b0;
        i_accept = 1'b1;
        tick();
        n_checks++;
        if (err_q.size() !== e0) begin
            n_fail++;
            $display("FAIL rst_noerr got=%0d exp=%0d", err_q.size(), e0);
        end
        r0 = rx_q.size();
        pl[0] = 8'hC1; pl[1] = 8'hC2; pl[2] = 8'hC3;
        send(SYNC); send(8'h03); send(pl[0]); send(pl[1]); send(pl[2]);
        send(8'h03 ^ pl[0] ^ pl[1] ^ pl[2]);
        wait_drain(1'b0);
        n_checks++;
        if (rx_q.size() - r0 !== 3) begin
            n_fail++;
            $display("FAIL rst_after_count got=%0d exp=3", rx_q.size() - r0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({rxl_q[r0+i], rx_q[r0+i]} !== {(i == 2), pl[i]}) begin
                    n_fail++;
                    $display("FAIL rst_after_b%0d got=%h exp=%h", i,
                             {rxl_q[r0+i], rx_q[r0+i]}, {(i == 2), pl[i]});
                end
            end
        end
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic test_random();
        logic [7:0] eb [$];
        bit         el [$];
        int         ee [$];
        int         eok = 0;
        int r0  = rx_q.size();
        int e0  = err_q.size();
        int ok0 = ok_cnt;
        int d0  = drop_cnt;
        i_accept = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int kind = int'($urandom_range(0, 9));
            int len;
            logic [7:0] cs;
            logic [7:0] b;
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send(b);
                gap();
            end
            len = (kind == 9) ? int'($urandom_range(ML + 1, 255))
                              : int'($urandom_range(0, ML));
            send(SYNC);
            gap();
            send(8'(len));
            gap();
            if (kind == 9) begin
                ee.push_back(1);
                continue;
            end
            cs = 8'(len);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                cs ^= b;
                if (kind < 7) begin
                    eb.push_back(b);
                    el.push_back(i == len - 1);
                end
                send(b);
                gap();
            end
            if (kind >= 7) begin
                send(cs ^ 8'($urandom_range(1, 255)));
                ee.push_back(2);
                gap();
            end else begin
                send(cs);
                eok++;
                if (len > 0) wait_drain(1'b1);
                gap();
            end
        end
        tick();
        n_checks++;
        if (rx_q.size() - r0 !== eb.size()) begin
            n_fail++;
            $display("FAIL rnd_bytes got=%0d exp=%0d", rx_q.size() - r0, eb.size());
        end else begin
            for (int i = 0; i < eb.size(); i++) begin
                n_checks++;
                if ({rxl_q[r0+i], rx_q[r0+i]} !== {el[i], eb[i]}) begin
                    n_fail++;
                    $display("FAIL rnd_byte%0d got=%h exp=%h", i,
                             {rxl_q[r0+i], rx_q[r0+i]}, {el[i], eb[i]});
                end
            end
        end
        n_checks++;
        if (err_q.size() - e0 !== ee.size()) begin
            n_fail++;
            $display("FAIL rnd_errs got=%0d exp=%0d", err_q.size() - e0, ee.size());
        end else begin
            for (int i = 0; i < ee.size(); i++) begin
                n_checks++;
                if (err_q[e0+i] !== ee[i]) begin
                    n_fail++;
                    $display("FAIL rnd_code%0d got=%0d exp=%0d", i, err_q[e0+i], ee[i]);
                end
            end
        end
        n_checks++;
        if (ok_cnt - ok0 !== eok) begin
            n_fail++;
            $display("FAIL rnd_ok got=%0d exp=%0d", ok_cnt - ok0, eok);
        end
        n_checks++;
        if (drop_cnt - d0 !== 0) begin
            n_fail++;
            $display("FAIL rnd_drop got=%0d exp=0", drop_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
